instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 46 ++++
 rtl/instr_field_enc.sv | 45 ++++
 rtl/instr_encoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared instruction-set defines: the micro-op kind enum, the opcode and
// funct constants, and small word-packing helpers. The control decoder
// imports the same package, so encoder and decoder cannot diverge.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_NOR, OP_SLL, OP_SRL,
    OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_BEQ, OP_BNE, OP_J
  } op_kind_e;

  // Major opcodes
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} enc_state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_enc.sv
// Combinational field encoder: packs one micro-op into a 32-bit instruction.
// Ports: op_kind/rs/rt/rd/shamt/imm/target in; word (encoded instruction)
// and valid (op_kind is a defined operation) out.
module instr_field_enc
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  op_kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        valid
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    word  = '0;
    valid = 1'b1;
    // shamt only carries meaning for shifts; shifts take their source in rt, so rs is zeroed.
    case (op_kind_e'(op_kind))
      OP_ADD:  word = r_word(rs, rt, rd, 5'd0, FUNCT_ADD);
      OP_SUB:  word = r_word(rs, rt, rd, 5'd0, FUNCT_SUB);
      OP_AND:  word = r_word(rs, rt, rd, 5'd0, FUNCT_AND);
      OP_OR:   word = r_word(rs, rt, rd, 5'd0, FUNCT_OR);
      OP_SLT:  word = r_word(rs, rt, rd, 5'd0, FUNCT_SLT);
      OP_NOR:  word = r_word(rs, rt, rd, 5'd0, FUNCT_NOR);
      OP_SLL:  word = r_word(5'd0, rt, rd, shamt, FUNCT_SLL);
      OP_SRL:  word = r_word(5'd0, rt, rd, shamt, FUNCT_SRL);
      OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
      OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
      OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
      OP_ANDI: word = i_word(OPC_ANDI, rs, rt, imm);
      OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
      OP_SLTI: word = i_word(OPC_SLTI, rs, rt, imm);
      OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
      OP_BNE:  word = i_word(OPC_BNE, rs, rt, imm);
      OP_J:    word = {OPC_J, target};
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: accepts micro-ops during a start/finish session,
// encodes them, and writes one word per cycle through a one-entry output stage.
// Ports: clk, rst (async, active high); start/finish session pulses;
// in_valid/in_ready + op fields (micro-op input); imem_we/imem_ready/
// imem_addr/imem_wdata (memory write handshake); busy, done (pulse),
// err (sticky, undefined op seen), word_count (words accepted this session).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  enc_state_e  state;
  logic [31:0] enc_word;
  logic        enc_valid;
  logic        full;
  logic        accept;
  logic        write_done;

  instr_field_enc u_field_enc (
    .op_kind (op_kind),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .imm     (imm),
    .target  (target),
    .word    (enc_word),
    .valid   (enc_valid)
  );

  // The session holds at most 2^ADDR_W words: the count's top bit marks full.
  assign full       = word_count[ADDR_W];
  assign write_done = imem_we & imem_ready;
  // The stage can take a new word when empty or when it empties this cycle.
  assign in_ready   = (state == ST_LOAD) && !full && (!imem_we || imem_ready);
  assign accept     = in_valid & in_ready;
  assign busy       = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      done <= 1'b0;

      // imem_addr always names the word in (or next into) the stage.
      if (write_done) begin
        imem_we   <= 1'b0;
        imem_addr <= imem_addr + ADDR_W'(1);
      end

      // Undefined ops are consumed but flagged; they produce no word.
      if (accept) begin
        if (enc_valid) begin
          imem_we    <= 1'b1;
          imem_wdata <= enc_word;
          word_count <= word_count + (ADDR_W+1)'(1);
        end else begin
          err <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (finish || full) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!imem_we || imem_ready) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
